// File: rtl/mem_io_unit.sv
// mem_io_unit: word-organised RAM below IO_BASE plus three memory-mapped
// registers above it (TX byte FIFO, STATUS, free-running CYCLES counter).
//
// TX stream handshake: out_tx_valid is high whenever the FIFO holds a byte and
// out_tx_data is then the head byte; a byte transfers on any rising clk edge
// where out_tx_valid and in_tx_ready are both high. While valid is high the
// head byte never changes until it transfers. in_tx_ready is ignored while
// out_tx_valid is low. The byte bus reads 0 when the FIFO is empty.
module mem_io_unit #(
  parameter int          MEM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_address_bus,
  input  logic        in_mem_write_en,
  input  logic [31:0] in_mem_write_data,
  output logic [31:0] out_mem_read_data,
  output logic [7:0]  out_tx_data,
  output logic        out_tx_valid,
  input  logic        in_tx_ready
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);

  // Word offsets of the registers inside the I/O window
  localparam logic [29:0] OFF_TXDATA = 30'd0;
  localparam logic [29:0] OFF_STATUS = 30'd1;
  localparam logic [29:0] OFF_CYCLES = 30'd2;

  // Storage
  logic [31:0]   r_mem [MEM_WORDS];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_count;
  logic          r_overflow;
  logic [31:0]   r_cycles;

  // Address decode
  logic          w_is_io;
  logic [31:0]   w_io_off;
  logic [29:0]   w_io_word;
  logic [AW-1:0] w_ram_idx;
  logic          w_sel_tx;
  logic          w_sel_status;
  logic          w_sel_cycles;

  // FIFO control
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push_req;
  logic          w_push;
  logic          w_ovf_set;
  logic          w_ovf_clr;
  logic [31:0]   w_count32;
  logic [3:0]    w_occ;
  logic [31:0]   w_status;

  assign w_is_io      = (in_address_bus >= IO_BASE);
  assign w_io_off     = in_address_bus - IO_BASE;
  assign w_io_word    = w_io_off[31:2];
  assign w_ram_idx    = in_address_bus[AW+1:2];
  assign w_sel_tx     = w_is_io && (w_io_word == OFF_TXDATA);
  assign w_sel_status = w_is_io && (w_io_word == OFF_STATUS);
  assign w_sel_cycles = w_is_io && (w_io_word == OFF_CYCLES);

  assign w_full     = (r_count == (PW+1)'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_pop      = !w_empty && in_tx_ready;
  assign w_push_req = in_mem_write_en && w_sel_tx;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && w_full && !w_pop;
  assign w_ovf_clr  = in_mem_write_en && w_sel_status && in_mem_write_data[2];

  // Occupancy is shown in a 4-bit field, saturating at 15
  assign w_count32 = 32'(r_count);
  assign w_occ     = (w_count32 > 32'd15) ? 4'hF : w_count32[3:0];
  assign w_status  = {20'd0, w_occ, 5'd0, r_overflow, w_empty, w_full};

  assign out_tx_valid = !w_empty;
  assign out_tx_data  = w_empty ? 8'h00 : r_fifo[r_rd_ptr];

  // RAM write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (in_mem_write_en && !w_is_io) begin
      r_mem[w_ram_idx] <= in_mem_write_data;
    end
  end

  // FIFO byte storage; only slots between the pointers are ever observed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= in_mem_write_data[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
      // Setting takes priority over a clear in the same cycle
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (w_ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Free-running cycle counter; a CYCLES write replaces that cycle's increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycles <= 32'd0;
    end else if (in_mem_write_en && w_sel_cycles) begin
      r_cycles <= in_mem_write_data;
    end else begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  // Combinational read mux for the current address
  always_comb begin
    out_mem_read_data = 32'd0;
    if (!w_is_io) begin
      out_mem_read_data = r_mem[w_ram_idx];
    end else if (w_sel_status) begin
      out_mem_read_data = w_status;
    end else if (w_sel_cycles) begin
      out_mem_read_data = r_cycles;
    end
  end

endmodule

// File: tb/tb_mem_io_unit.sv
// Testbench for mem_io_unit: directed vectors with literal expectations plus
// a per-cycle comparison against a queue/array-based behavioural model.
module tb_mem_io_unit;

  localparam int          MEM_WORDS  = 1024;
  localparam int          FIFO_DEPTH = 8;
  localparam logic [31:0] IO_BASE    = 32'hFFFF_0000;
  localparam logic [31:0] A_TX       = IO_BASE + 32'h0;
  localparam logic [31:0] A_STATUS   = IO_BASE + 32'h4;
  localparam logic [31:0] A_CYCLES   = IO_BASE + 32'h8;
  localparam logic [31:0] A_UNMAP    = IO_BASE + 32'hC;

  // ---------------- clock / reset ----------------
  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr  = A_STATUS;
  logic        we    = 1'b0;
  logic [31:0] wd    = 32'd0;
  logic        rdy   = 1'b0;
  logic [31:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;

  always #5 clk = ~clk;

  mem_io_unit #(
    .MEM_WORDS (MEM_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .IO_BASE   (IO_BASE)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in_address_bus   (addr),
    .in_mem_write_en  (we),
    .in_mem_write_data(wd),
    .out_mem_read_data(rd_data),
    .out_tx_data      (tx_data),
    .out_tx_valid     (tx_valid),
    .in_tx_ready      (rdy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  exp_q[$];
  logic [31:0] ram_m [int];
  logic        m_ovf = 1'b0;
  logic [31:0] m_cnt = 32'd0;

  function automatic int ram_index(input logic [31:0] a);
    return int'((a >> 2) % MEM_WORDS);
  endfunction

  function automatic logic [31:0] m_status();
    int n;
    n = exp_q.size();
    if (n > 15) n = 15;
    return (32'(n) << 8) | (m_ovf ? 32'h4 : 32'h0) |
           ((n == 0) ? 32'h2 : 32'h0) |
           ((exp_q.size() == FIFO_DEPTH) ? 32'h1 : 32'h0);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_cnt = 32'd0;
    end else begin
      logic is_io, pop, preq, was_full;
      logic [31:0] word;
      is_io    = (addr >= IO_BASE);
      word     = (addr - IO_BASE) >> 2;
      was_full = (exp_q.size() == FIFO_DEPTH);
      pop      = (exp_q.size() > 0) && rdy;
      preq     = we && is_io && (word == 0);
      if (pop) void'(exp_q.pop_front());
      if (preq && (!was_full || pop)) exp_q.push_back(wd[7:0]);
      if (preq && was_full && !pop) m_ovf = 1'b1;
      else if (we && is_io && word == 1 && wd[2]) m_ovf = 1'b0;
      if (we && is_io && word == 2) m_cnt = wd;
      else m_cnt = m_cnt + 32'd1;
      if (we && !is_io) ram_m[ram_index(addr)] = wd;
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    logic [31:0] word;
    chk("tx_valid", {31'd0, tx_valid}, {31'd0, (exp_q.size() > 0)});
    chk("tx_data", {24'd0, tx_data}, {24'd0, (exp_q.size() > 0) ? exp_q[0] : 8'h00});
    if (addr >= IO_BASE) begin
      word = (addr - IO_BASE) >> 2;
      if (word == 1)      chk("rd_status", rd_data, m_status());
      else if (word == 2) chk("rd_cycles", rd_data, m_cnt);
      else                chk("rd_io_zero", rd_data, 32'd0);
    end else if (ram_m.exists(ram_index(addr))) begin
      chk("rd_ram", rd_data, ram_m[ram_index(addr)]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] d, input logic r);
    @(posedge clk);
    #1;
    addr = a;
    we   = w;
    wd   = d;
    rdy  = r;
  endtask

  task automatic expect_rd(input string name, input logic [31:0] exp);
    @(negedge clk);
    chk(name, rd_data, exp);
  endtask

  task automatic expect_tx(input string name, input logic [7:0] exp);
    @(negedge clk);
    chk(name, {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, exp});
  endtask

  // Watchdog: the sequence is linear, this only guards against a stuck run
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {31'd0, tx_valid}, 32'd0);
    chk("reset_txdata", {24'd0, tx_data}, 32'd0);
    addr = A_CYCLES;
    reset = 1'b1;
    expect_rd("cycles_first", 32'd0);
    drive(A_STATUS, 1'b0, 32'd0, 1'b0);
    expect_rd("status_reset", 32'h0000_0002);

    // RAM write/read and wrap
    drive(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 1'b0);
    drive(32'h0000_0010, 1'b0, 32'd0, 1'b0);
    expect_rd("ram_rd", 32'hDEAD_BEEF);
    drive(32'h0000_0010 + 4 * MEM_WORDS, 1'b0, 32'd0, 1'b0);
    expect_rd("ram_wrap", 32'hDEAD_BEEF);
    drive(32'h0000_0013, 1'b0, 32'd0, 1'b0);
    expect_rd("ram_low_bits", 32'hDEAD_BEEF);
    drive(32'h0000_000C, 1'b1, 32'hCAFE_F00D, 1'b0);

    // Reset in the middle of a transfer
    drive(A_TX, 1'b1, 32'h77, 1'b0);
    drive(A_STATUS, 1'b0, 32'd0, 1'b0);
    expect_tx("pre_reset_head", 8'h77);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_valid", {31'd0, tx_valid}, 32'd0);
    chk("async_reset_txdata", {24'd0, tx_data}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    expect_rd("status_after_reset", 32'h0000_0002);
    drive(32'h0000_0010, 1'b0, 32'd0, 1'b0);
    expect_rd("ram_survives_reset", 32'hDEAD_BEEF);

    // FIFO fill and overflow with ready low
    for (int i = 0; i < 8; i++) drive(A_TX, 1'b1, 32'h41 + 32'(i), 1'b0);
    drive(A_STATUS, 1'b0, 32'd0, 1'b0);
    expect_rd("status_full", 32'h0000_0801);
    drive(A_TX, 1'b1, 32'h49, 1'b0);
    drive(A_STATUS, 1'b0, 32'd0, 1'b0);
    expect_rd("status_overflow", 32'h0000_0805);
    for (int i = 0; i < 8; i++) begin
      drive(A_STATUS, 1'b0, 32'd0, 1'b1);
      expect_tx("drain_order", 8'(8'h41 + i));
    end
    drive(A_STATUS, 1'b0, 32'd0, 1'b0);
    expect_rd("status_drained_ovf", 32'h0000_0006);
    drive(A_STATUS, 1'b1, 32'h4, 1'b0);
    drive(A_STATUS, 1'b0, 32'd0, 1'b0);
    expect_rd("status_ovf_cleared", 32'h0000_0002);

    // Simultaneous push and pop while full
    for (int i = 0; i < 8; i++) drive(A_TX, 1'b1, 32'h50 + 32'(i), 1'b0);
    drive(A_TX, 1'b1, 32'h5A, 1'b1);
    drive(A_STATUS, 1'b0, 32'd0, 1'b0);
    expect_rd("status_push_pop_full", 32'h0000_0801);
    for (int i = 1; i < 8; i++) begin
      drive(A_STATUS, 1'b0, 32'd0, 1'b1);
      expect_tx("pp_drain", 8'(8'h50 + i));
    end
    drive(A_STATUS, 1'b0, 32'd0, 1'b1);
    expect_tx("pp_last", 8'h5A);
    drive(A_STATUS, 1'b0, 32'd0, 1'b0);
    expect_rd("status_pp_empty", 32'h0000_0002);

    // Push and pop with exactly one entry keeps count at 1
    drive(A_TX, 1'b1, 32'h61, 1'b0);
    drive(A_TX, 1'b1, 32'h62, 1'b1);
    drive(A_STATUS, 1'b0, 32'd0, 1'b0);
    expect_rd("status_one_entry", 32'h0000_0100);
    drive(A_STATUS, 1'b0, 32'd0, 1'b1);
    expect_tx("one_entry_head", 8'h62);

    // Counter load and wrap
    drive(A_CYCLES, 1'b1, 32'hFFFF_FFFE, 1'b0);
    drive(A_CYCLES, 1'b0, 32'd0, 1'b0);
    expect_rd("cycles_load", 32'hFFFF_FFFE);
    drive(A_CYCLES, 1'b0, 32'd0, 1'b0);
    expect_rd("cycles_max", 32'hFFFF_FFFF);
    drive(A_CYCLES, 1'b0, 32'd0, 1'b0);
    expect_rd("cycles_wrap", 32'h0000_0000);

    // Unmapped I/O offset and TXDATA reads
    drive(A_UNMAP, 1'b1, 32'h1234, 1'b0);
    drive(A_UNMAP, 1'b0, 32'd0, 1'b0);
    expect_rd("unmapped_rd", 32'd0);
    drive(A_TX, 1'b0, 32'd0, 1'b0);
    expect_rd("txdata_rd", 32'd0);
    drive(32'h0000_000C, 1'b0, 32'd0, 1'b0);
    expect_rd("ram_c_unchanged", 32'hCAFE_F00D);

    drive(A_STATUS, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_io_unit.md
# mem_io_unit

Memory-side block that sits directly downstream of the CPU core: it consumes the core's address bus, write-enable and write-data, and returns read data. Addresses below `IO_BASE` hit a word-organised data/instruction RAM. Addresses from `IO_BASE` upward reach three memory-mapped registers: a byte-stream transmit FIFO with a valid/ready output, a status register and a free-running cycle counter.

## Interface
- `MEM_WORDS`, 1024: RAM depth in 32-bit words (power of two).
- `FIFO_DEPTH`, 8: TX FIFO depth in bytes (power of two, ≥2).
- `IO_BASE`, 32'hFFFF_0000: base byte address of the I/O window (64 KiB aligned).
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = asserted).
- `in_address_bus`  in  32  byte address from the core's address register.
- `in_mem_write_en`  in  1  write strobe for the current address.
- `in_mem_write_data`  in  32  write data.
- `out_mem_read_data`  out  32  read data for the current address (combinational).
- `out_tx_data`  out  8  FIFO head byte; 0 when FIFO empty.
- `out_tx_valid`  out  1  FIFO non-empty.
- `in_tx_ready`  in  1  consumer accepts head byte this cycle.

## Operation
- Decode: `in_address_bus >= IO_BASE` selects I/O, else RAM. Address bits [1:0] ignored everywhere.
- RAM: index = `in_address_bus[log2(MEM_WORDS)+1:2]`; higher bits ignored, so addresses wrap modulo MEM_WORDS words. Read is asynchronous from the array. Write happens at clk edge when `in_mem_write_en`=1. RAM contents are not reset.
- IO_BASE+0x0 TXDATA:
  - Write pushes `in_mem_write_data[7:0]`.
  - Read returns 0.
- IO_BASE+0x4 STATUS, read value:
  - bit0 full, bit1 empty, bit2 overflow (sticky).
  - bits[11:8] occupancy count (zero-extended, saturates display at 15).
  - Other bits 0.
  - Write with data bit2=1 clears overflow; other bits are ignored.
- IO_BASE+0x8 CYCLES:
  - Read returns the 32-bit counter.
  - Write loads `in_mem_write_data`.
- Any other I/O offset: reads 0, writes have no effect.
- FIFO:
  - Circular buffer with read/write pointers and a count.
  - Pop when `out_tx_valid & in_tx_ready`.
  - Push when a TXDATA write occurs and (not full, or a pop happens in the same cycle).
  - A push attempted while full with no simultaneous pop drops the byte and sets overflow.
  - Push and pop together leave the count unchanged, including when full or when there was 1 entry.
  - Pop while empty is impossible because valid=0.
- Counter: increments by 1 every cycle and wraps 32'hFFFF_FFFF→0. In a cycle with a CYCLES write, the loaded value takes effect and there is no increment that cycle.
- Overflow set and clear in the same cycle: set wins.

## Timing
- Reset (asynchronous assert, synchronous effect on release):
  - FIFO empty, pointers 0, overflow 0, counter 0.
  - `out_tx_valid`=0, `out_tx_data`=0.
  - `out_mem_read_data` follows the decode combinationally; for example, STATUS reads 32'h2.
- RAM read latency is 0 cycles (combinational). Write data is visible on a read in the cycle after the write edge.
- A pushed byte appears on `out_tx_data`/`out_tx_valid` the cycle after the write edge. A byte remains stable until it is popped.
- STATUS and CYCLES reads reflect register state before the current edge. After a CYCLES write of V, reads return V, V+1, ... in the following cycles.
- Reset asserted mid-transfer empties the FIFO immediately and drops `out_tx_valid` without waiting for a clock edge. The RAM is untouched.
- `in_tx_ready` may be high while `out_tx_valid`=0; it is ignored.

## Test plan
- RAM write/read and wrap:
  - Write 32'hDEADBEEF to 0x0000_0010, then read 0x10 → DEADBEEF.
  - Read 0x10 + 4*MEM_WORDS → DEADBEEF.
  - Read 0x13 → DEADBEEF.
- Reset values:
  - Assert reset with no clock edge → `out_tx_valid`=0 immediately.
  - After release, read STATUS → 32'h0000_0002; read CYCLES on the first post-reset cycle → 0.
- FIFO fill/overflow with `in_tx_ready`=0:
  - Push 0x41..0x48 (8 bytes) → STATUS = 32'h0000_0801.
  - 9th push 0x49 → STATUS = 32'h0000_0805.
  - Drain with ready=1 → bytes 0x41..0x48 in order, no 0x49.
  - Write STATUS 0x4 → overflow cleared.
- Simultaneous push/pop when full:
  - With 8 entries, ready=1, push 0x5A in the same cycle → count stays 8, head advances.
  - 0x5A emerges last; overflow stays 0.
- Counter:
  - Write CYCLES 32'hFFFF_FFFE → next reads FFFF_FFFE, FFFF_FFFF, 0000_0000.
- Unmapped I/O:
  - Write 0x1234 to IO_BASE+0xC, read it back → 0.
  - RAM word 0x0000_000C unchanged.
